// File: rtl/ram_rw_arbiter.sv
// Shares the single ram_rw port between instruction fetch (IF) and load/store (LS).
// LS has priority, but a run of LS grants is capped so IF is not starved; a watchdog ends hung accesses.
module ram_rw_arbiter #(
   parameter int LS_MAX_CONSEC = 4,
   parameter int TIMEOUT_CYC   = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [63:0] if_addr_i,
   input  logic [2:0]  if_size_i,
   input  logic        if_flush_i,
   output logic        if_gnt_o,
   output logic        if_resp_valid_o,
   output logic [63:0] if_resp_data_o,
   output logic        if_resp_err_o,
   input  logic        ls_req_i,
   input  logic        ls_wen_i,
   input  logic [63:0] ls_addr_i,
   input  logic [63:0] ls_wdata_i,
   input  logic [7:0]  ls_wmask_i,
   input  logic [2:0]  ls_size_i,
   output logic        ls_gnt_o,
   output logic        ls_resp_valid_o,
   output logic [63:0] ls_resp_data_o,
   output logic        ls_resp_err_o,
   output logic        ram_rw_cen_o,
   output logic        ram_rw_wen_o,
   output logic [63:0] ram_rw_addr_o,
   output logic [63:0] ram_rw_wdata_o,
   output logic [7:0]  ram_rw_wmask_o,
   output logic [2:0]  ram_rw_size_o,
   input  logic        ram_rw_ready_i,
   input  logic [63:0] ram_rw_data_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

   state_t     state;
   state_t     state_next;
   logic       owner_ls;
   logic [3:0] consec_cnt;
   logic [3:0] tmo_cnt;
   logic       flushed;
   logic       pick_if;
   logic       timeout;
   logic       done;
   logic       arb_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Arbitration happens in IDLE or on the cycle a WAIT access completes, so back-to-back
   // accesses need only two cycles each. Grants are masked during reset.
   always_comb begin
      state_next      = state;
      pick_if         = if_req_i && (!ls_req_i || consec_cnt == 4'(LS_MAX_CONSEC));
      timeout         = (state == ST_WAIT) && !ram_rw_ready_i && (tmo_cnt == 4'(TIMEOUT_CYC - 1));
      done            = (state == ST_WAIT) && (ram_rw_ready_i || timeout);
      arb_ok          = rst_n && ((state == ST_IDLE) || done);
      if_gnt_o        = arb_ok && pick_if;
      ls_gnt_o        = arb_ok && ls_req_i && !pick_if;
      ram_rw_cen_o    = (state == ST_REQ);
      busy_o          = (state != ST_IDLE);
      if_resp_valid_o = 1'b0;
      if_resp_data_o  = '0;
      if_resp_err_o   = 1'b0;
      ls_resp_valid_o = 1'b0;
      ls_resp_data_o  = '0;
      ls_resp_err_o   = 1'b0;
      case (state)
         ST_IDLE: if (if_req_i || ls_req_i) state_next = ST_REQ;
         ST_REQ:  state_next = ST_WAIT;
         ST_WAIT: if (done) state_next = (if_req_i || ls_req_i) ? ST_REQ : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (done) begin
         if (owner_ls) begin
            ls_resp_valid_o = 1'b1;
            ls_resp_err_o   = timeout;
            ls_resp_data_o  = (ram_rw_ready_i && !ram_rw_wen_o) ? ram_rw_data_i : '0;
         end else if (!flushed && !if_flush_i) begin
            if_resp_valid_o = 1'b1;
            if_resp_err_o   = timeout;
            if_resp_data_o  = ram_rw_ready_i ? ram_rw_data_i : '0;
         end
      end
   end

   // The RAM-side fields are captured at grant time and held until the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_ls       <= 1'b0;
         consec_cnt     <= '0;
         tmo_cnt        <= '0;
         flushed        <= 1'b0;
         ram_rw_wen_o   <= 1'b0;
         ram_rw_addr_o  <= '0;
         ram_rw_wdata_o <= '0;
         ram_rw_wmask_o <= '0;
         ram_rw_size_o  <= '0;
      end else begin
         if (if_gnt_o) begin
            owner_ls       <= 1'b0;
            ram_rw_wen_o   <= 1'b0;
            ram_rw_wmask_o <= '0;
            ram_rw_addr_o  <= if_addr_i;
            ram_rw_size_o  <= if_size_i;
         end else if (ls_gnt_o) begin
            owner_ls       <= 1'b1;
            ram_rw_wen_o   <= ls_wen_i;
            ram_rw_wmask_o <= ls_wmask_i;
            ram_rw_addr_o  <= ls_addr_i;
            ram_rw_wdata_o <= ls_wdata_i;
            ram_rw_size_o  <= ls_size_i;
         end
         if (!if_req_i || if_gnt_o)
            consec_cnt <= '0;
         else if (ls_gnt_o && consec_cnt != 4'(LS_MAX_CONSEC))
            consec_cnt <= consec_cnt + 4'd1;
         if (state == ST_REQ)
            tmo_cnt <= '0;
         else if (state == ST_WAIT)
            tmo_cnt <= tmo_cnt + 4'd1;
         if (done)
            flushed <= 1'b0;
         else if (if_flush_i && !owner_ls && (state != ST_IDLE))
            flushed <= 1'b1;
      end
   end

endmodule
